int_issue_queue: RTL and testbench
==================================

// Module: int_issue_queue
// PURPOSE
//  Age-ordered reservation station for integer ops, feeding the integer execution port of the CDB arbiter.
//  - Accepts dispatched ops with operands that are either captured or pending (ROB tag).
//  - Snoops the CDB to wake pending operands.
//  - Selects the oldest op with both operands ready and presents it to the integer ALU / arbiter.
//  - Pops that op on int_issue.
// PARAMETERS
//  DEPTH   4   queue entries (2..8)
//  TAG_W   5   ROB tag width
//  DATA_W  32  operand width
//  OPC_W   4   integer opcode width
// PORTS
//  clock        in   1       single clock, rising edge
//  nreset       in   1       synchronous, active-low reset
//  flush_valid  in   1       mispredict flush: empty the queue
//  disp_valid   in   1       dispatch request
//  disp_ready   out  1       queue can accept a dispatch this cycle
//  disp_opcode  in   OPC_W   op to execute
//  disp_tag     in   TAG_W   destination ROB tag
//  disp_rs_rdy  in   1       rs value present in disp_rs_data
//  disp_rs_data in   DATA_W  rs value
//  disp_rs_tag  in   TAG_W   producer tag of rs when not ready
//  disp_rt_rdy  in   1       rt value present in disp_rt_data
//  disp_rt_data in   DATA_W  rt value
//  disp_rt_tag  in   TAG_W   producer tag of rt when not ready
//  cdb_valid    in   1       CDB broadcast valid
//  cdb_tag      in   TAG_W   CDB result tag
//  cdb_data     in   DATA_W  CDB result data
//  int_ready    out  1       selected op ready for execution
//  int_opcode   out  OPC_W   selected op
//  int_rs_data  out  DATA_W  selected rs operand
//  int_rt_data  out  DATA_W  selected rt operand
//  int_tag      out  TAG_W   selected destination tag
//  int_issue    in   1       arbiter grant: selected op leaves the queue this cycle
// BEHAVIOUR
//  Reset (nreset=0 at posedge): all entries invalid, count=0.
//  - Outputs: int_ready=0, int_* = 0 (zeroed whenever int_ready=0), disp_ready=1.
//  Storage: entry 0 is oldest. Collapsing queue: an issued entry is removed and every younger entry shifts down one slot in the same cycle.
//  Select (combinational, from registered state only):
//  - Lowest index with valid & rs_rdy & rt_rdy; int_* driven from it.
//  - An operand woken in cycle N makes its entry selectable from cycle N+1.
//  Issue: int_issue & int_ready removes the selected entry at posedge. int_issue with int_ready=0 is ignored.
//  Dispatch: disp_ready = (count < DEPTH), registered count.
//  - No same-cycle credit from an issue, so a full queue stalls one cycle even when issuing.
//  - disp_valid & disp_ready writes slot count, or count-1 if an issue happens in the same cycle.
//  - disp_valid with disp_ready=0 is ignored.
//  Wakeup: on cdb_valid, every valid entry with a pending operand whose tag equals cdb_tag captures cdb_data and sets that operand ready.
//  - Both operands may wake in the same cycle.
//  - The same tag match applies to the incoming dispatch (bypass), so a producer broadcasting in the dispatch cycle is never missed.
//  - An entry issuing this cycle needs no wakeup.
//  Simultaneous dispatch + issue + wakeup in one cycle: all take effect at that posedge; the shifted entries keep their wakeups.
//  Flush (priority below reset, above all else): all entries invalid next cycle, count=0.
//  - A same-cycle dispatch is dropped.
//  - int_issue and CDB are ignored that cycle.
//  Reset asserted mid-operation behaves as flush plus reset values.
//  count is clog2(DEPTH+1) bits wide; it never wraps because the queue never accepts beyond DEPTH.
// STRUCTURE
//  Shared header mips_defs.vh: TAG_W, DATA_W, OPC_W defaults and integer opcode encodings (ALU, branch).
//  Sub-module iq_oldest_select: DEPTH-bit ready vector in, one-hot grant plus index out (priority to index 0).
//  The entry array, shift/insert logic and wakeup compare stay in this module.
// TESTING
//  1 Reset -> int_ready=0, disp_ready=1, int_tag=0.
//  2 Dispatch tag=3, rs=5, rt=7, both ready; next cycle int_ready=1, int_tag=3, rs=5, rt=7.
//    Pulse int_issue -> int_ready=0 the following cycle.
//  3 Dispatch tag=4 with rs pending on tag 9; cycle later cdb_valid, tag=9, data=0x1234 -> int_ready=1 next cycle with int_rs_data=0x1234.
//  4 Dispatch rt pending on tag 9 in the same cycle as CDB tag=9, data=0xBEEF -> entry ready next cycle, int_rt_data=0xBEEF.
//  5 Fill 4 entries, only slots 1 and 3 ready -> slot 1 tag presented first; disp_ready=0.
//    A disp_valid while full is dropped; after the issue, the slot 3 op is presented next and disp_ready=1.
//  6 Queue holds 3 entries; flush_valid together with disp_valid and int_issue -> next cycle empty, int_ready=0, disp_ready=1.

Source files
------------

// File: rtl/int_issue_queue_pkg.sv
// -----------------------------------------------------------------------------
// int_issue_queue_pkg
// Shared defaults and encodings for the integer issue queue slice.
//   - Default geometry of the queue: depth, ROB tag, operand and opcode widths.
//   - Integer opcode encodings (ALU and branch groups) carried through the queue.
//   - Width helpers used to size the occupancy counter and slot index.
// -----------------------------------------------------------------------------
package int_issue_queue_pkg;

  localparam int IQ_DEPTH  = 4;
  localparam int IQ_TAG_W  = 5;
  localparam int IQ_DATA_W = 32;
  localparam int IQ_OPC_W  = 4;

  // Integer opcodes; the queue treats these as opaque payload.
  typedef enum logic [3:0] {
    OPC_ADD = 4'h0,
    OPC_SUB = 4'h1,
    OPC_AND = 4'h2,
    OPC_OR  = 4'h3,
    OPC_XOR = 4'h4,
    OPC_SLT = 4'h5,
    OPC_SLL = 4'h6,
    OPC_SRL = 4'h7,
    OPC_BEQ = 4'h8,
    OPC_BNE = 4'h9
  } int_opc_e;

  // Counter must hold 0..depth inclusive, hence depth+1 values.
  function automatic int iq_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Slot index width; depth is at least 2 so this is never zero.
  function automatic int iq_idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/int_issue_queue_if.sv
// -----------------------------------------------------------------------------
// int_issue_queue_if
// Bundles the dispatch, CDB snoop, flush and issue signals of the integer
// issue queue.
//   master : dispatcher / CDB / arbiter side (drives requests, sees status)
//   slave  : the issue queue itself
// Signals:
//   flush_valid                      mispredict flush
//   disp_valid / disp_ready          dispatch handshake
//   disp_opcode, disp_tag            op and destination ROB tag
//   disp_rs_* / disp_rt_*            operand value or pending producer tag
//   cdb_valid, cdb_tag, cdb_data     result broadcast being snooped
//   int_ready, int_opcode, int_tag,
//   int_rs_data, int_rt_data         oldest ready op presented to the ALU
//   int_issue                        arbiter grant, pops the presented op
// -----------------------------------------------------------------------------
interface int_issue_queue_if
  import int_issue_queue_pkg::*;
#(
  parameter int TAG_W  = IQ_TAG_W,
  parameter int DATA_W = IQ_DATA_W,
  parameter int OPC_W  = IQ_OPC_W
) ();

  logic              flush_valid;
  logic              disp_valid;
  logic              disp_ready;
  logic [OPC_W-1:0]  disp_opcode;
  logic [TAG_W-1:0]  disp_tag;
  logic              disp_rs_rdy;
  logic [DATA_W-1:0] disp_rs_data;
  logic [TAG_W-1:0]  disp_rs_tag;
  logic              disp_rt_rdy;
  logic [DATA_W-1:0] disp_rt_data;
  logic [TAG_W-1:0]  disp_rt_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              int_ready;
  logic [OPC_W-1:0]  int_opcode;
  logic [DATA_W-1:0] int_rs_data;
  logic [DATA_W-1:0] int_rt_data;
  logic [TAG_W-1:0]  int_tag;
  logic              int_issue;

  modport master (
    output flush_valid, disp_valid, disp_opcode, disp_tag,
           disp_rs_rdy, disp_rs_data, disp_rs_tag,
           disp_rt_rdy, disp_rt_data, disp_rt_tag,
           cdb_valid, cdb_tag, cdb_data, int_issue,
    input  disp_ready, int_ready, int_opcode, int_rs_data, int_rt_data, int_tag
  );

  modport slave (
    input  flush_valid, disp_valid, disp_opcode, disp_tag,
           disp_rs_rdy, disp_rs_data, disp_rs_tag,
           disp_rt_rdy, disp_rt_data, disp_rt_tag,
           cdb_valid, cdb_tag, cdb_data, int_issue,
    output disp_ready, int_ready, int_opcode, int_rs_data, int_rt_data, int_tag
  );

endinterface

// File: rtl/int_issue_queue_select.sv
// -----------------------------------------------------------------------------
// iq_oldest_select
// Fixed-priority picker: index 0 (the oldest slot) wins.
// Ports:
//   req_i  in  N       per-slot ready vector
//   gnt_o  out N       one-hot grant (all zero when nothing requests)
//   idx_o  out IDX_W   binary index of the granted slot (0 when none)
//   any_o  out 1       at least one slot requests
// -----------------------------------------------------------------------------
module iq_oldest_select
  import int_issue_queue_pkg::*;
#(
  parameter int N     = IQ_DEPTH,
  parameter int IDX_W = iq_idx_width(N)
) (
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Isolate the lowest set bit, then encode it; OR-reduction keeps this if-free.
  always_comb begin
    gnt_o = req_i & (~req_i + N'(1));
    any_o = |req_i;
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      idx_o = idx_o | (gnt_o[i] ? IDX_W'(i) : IDX_W'(0));
    end
  end

endmodule

// File: rtl/int_issue_queue.sv
// -----------------------------------------------------------------------------
// int_issue_queue
// Age-ordered, collapsing reservation station for integer ops.
//   - Slot 0 holds the oldest op; valid slots are always contiguous from 0.
//   - Pending operands are woken by snooping the CDB (including a bypass onto
//     the op being dispatched in the same cycle).
//   - The oldest op with both operands ready is presented on int_*; a grant on
//     int_issue removes it and every younger slot shifts down one place.
// Ports:
//   clock   in  rising-edge clock
//   nreset  in  synchronous active-low reset
//   iq      slave modport of int_issue_queue_if (dispatch, CDB, flush, issue)
// -----------------------------------------------------------------------------
module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH,
  parameter int TAG_W  = IQ_TAG_W,
  parameter int DATA_W = IQ_DATA_W,
  parameter int OPC_W  = IQ_OPC_W
) (
  input  logic             clock,
  input  logic             nreset,
  int_issue_queue_if.slave iq
);

  localparam int CNT_W = iq_cnt_width(DEPTH);
  localparam int IDX_W = iq_idx_width(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [OPC_W-1:0]  opc;
    logic [TAG_W-1:0]  tag;
    logic              rs_rdy;
    logic [DATA_W-1:0] rs_data;
    logic [TAG_W-1:0]  rs_tag;
    logic              rt_rdy;
    logic [DATA_W-1:0] rt_data;
    logic [TAG_W-1:0]  rt_tag;
  } entry_t;

  localparam entry_t ENTRY_EMPTY = '0;

  entry_t            entry_q   [DEPTH];
  entry_t            entry_d   [DEPTH];
  entry_t            woken_s   [DEPTH+1];
  entry_t            shifted_s [DEPTH];
  entry_t            disp_entry_s;
  entry_t            sel_entry_s;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [CNT_W-1:0]  ins_idx_s;
  logic [DEPTH-1:0]  ready_vec_s;
  logic [DEPTH-1:0]  sel_gnt_s;
  logic [IDX_W-1:0]  sel_idx_s;
  logic              sel_any_s;
  logic              disp_ready_s;
  logic              issue_fire_s;
  logic              disp_fire_s;

  // Capture a CDB broadcast into any pending operand of a valid entry whose
  // producer tag matches; both operands can wake at once.
  function automatic entry_t wake(input entry_t e, input logic cv,
                                  input logic [TAG_W-1:0] ct,
                                  input logic [DATA_W-1:0] cd);
    entry_t r;
    r = e;
    if (cv && e.valid && !e.rs_rdy && (e.rs_tag == ct)) begin
      r.rs_rdy  = 1'b1;
      r.rs_data = cd;
    end else begin
      r.rs_rdy  = e.rs_rdy;
    end
    if (cv && e.valid && !e.rt_rdy && (e.rt_tag == ct)) begin
      r.rt_rdy  = 1'b1;
      r.rt_data = cd;
    end else begin
      r.rt_rdy  = e.rt_rdy;
    end
    return r;
  endfunction

  // Per-slot readiness uses registered state only, so a wakeup seen this
  // cycle becomes selectable next cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec_s[i] = entry_q[i].valid & entry_q[i].rs_rdy & entry_q[i].rt_rdy;
    end
  end

  iq_oldest_select #(
    .N     (DEPTH),
    .IDX_W (IDX_W)
  ) u_select (
    .req_i (ready_vec_s),
    .gnt_o (sel_gnt_s),
    .idx_o (sel_idx_s),
    .any_o (sel_any_s)
  );

  // One-hot AND-OR mux of the granted slot; all-zero grant yields zeros, so
  // the int_* outputs are naturally cleared whenever nothing is ready.
  always_comb begin
    sel_entry_s = ENTRY_EMPTY;
    for (int i = 0; i < DEPTH; i++) begin
      sel_entry_s = sel_entry_s | (entry_q[i] & {$bits(entry_t){sel_gnt_s[i]}});
    end
  end

  // Issue-side and dispatch-side outputs.
  always_comb begin
    disp_ready_s   = (count_q < CNT_W'(DEPTH));
    iq.disp_ready  = disp_ready_s;
    iq.int_ready   = sel_any_s;
    iq.int_opcode  = sel_entry_s.opc;
    iq.int_tag     = sel_entry_s.tag;
    iq.int_rs_data = sel_entry_s.rs_data;
    iq.int_rt_data = sel_entry_s.rt_data;
  end

  // Handshake qualification; credit for an issue is not returned until the
  // registered count drops, so a full queue stalls a cycle even when issuing.
  always_comb begin
    issue_fire_s = iq.int_issue & sel_any_s;
    disp_fire_s  = iq.disp_valid & disp_ready_s;
    ins_idx_s    = issue_fire_s ? (count_q - CNT_W'(1)) : count_q;
  end

  // Apply the CDB snoop to every stored entry and to the incoming op. The
  // extra empty slot at index DEPTH feeds the top slot when the queue shifts.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken_s[i] = wake(entry_q[i], iq.cdb_valid, iq.cdb_tag, iq.cdb_data);
    end
    woken_s[DEPTH] = ENTRY_EMPTY;

    disp_entry_s         = ENTRY_EMPTY;
    disp_entry_s.valid   = 1'b1;
    disp_entry_s.opc     = iq.disp_opcode;
    disp_entry_s.tag     = iq.disp_tag;
    disp_entry_s.rs_rdy  = iq.disp_rs_rdy;
    disp_entry_s.rs_data = iq.disp_rs_data;
    disp_entry_s.rs_tag  = iq.disp_rs_tag;
    disp_entry_s.rt_rdy  = iq.disp_rt_rdy;
    disp_entry_s.rt_data = iq.disp_rt_data;
    disp_entry_s.rt_tag  = iq.disp_rt_tag;
    disp_entry_s         = wake(disp_entry_s, iq.cdb_valid, iq.cdb_tag, iq.cdb_data);
  end

  // Collapse: slots at or above the issued index take their younger
  // neighbour (already woken), then the new op lands at the first free slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      shifted_s[i] = (issue_fire_s && (IDX_W'(i) >= sel_idx_s)) ? woken_s[i+1] : woken_s[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (iq.flush_valid) begin
        entry_d[i] = ENTRY_EMPTY;
      end else begin
        entry_d[i] = (disp_fire_s && (CNT_W'(i) == ins_idx_s)) ? disp_entry_s : shifted_s[i];
      end
    end
  end

  // Occupancy update; flush overrides any dispatch or issue this cycle.
  always_comb begin
    count_d = count_q;
    if (iq.flush_valid) begin
      count_d = '0;
    end else begin
      case ({disp_fire_s, issue_fire_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        2'b11:   count_d = count_q;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= ENTRY_EMPTY;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_int_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_int_issue_queue
// Directed test of the integer issue queue with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_int_issue_queue;
  import int_issue_queue_pkg::*;

  logic clock;
  logic nreset;
  int   checks;
  int   errors;

  int_issue_queue_if #(.TAG_W(5), .DATA_W(32), .OPC_W(4)) iq ();

  int_issue_queue #(
    .DEPTH  (4),
    .TAG_W  (5),
    .DATA_W (32),
    .OPC_W  (4)
  ) dut (
    .clock  (clock),
    .nreset (nreset),
    .iq     (iq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    iq.flush_valid  = 1'b0;
    iq.disp_valid   = 1'b0;
    iq.disp_opcode  = 4'h0;
    iq.disp_tag     = 5'd0;
    iq.disp_rs_rdy  = 1'b0;
    iq.disp_rs_data = 32'h0;
    iq.disp_rs_tag  = 5'd0;
    iq.disp_rt_rdy  = 1'b0;
    iq.disp_rt_data = 32'h0;
    iq.disp_rt_tag  = 5'd0;
    iq.cdb_valid    = 1'b0;
    iq.cdb_tag      = 5'd0;
    iq.cdb_data     = 32'h0;
    iq.int_issue    = 1'b0;
  endtask

  task automatic set_disp(input logic [4:0] tag, input logic [3:0] opc,
                          input logic rs_rdy, input logic [31:0] rs_data, input logic [4:0] rs_tag,
                          input logic rt_rdy, input logic [31:0] rt_data, input logic [4:0] rt_tag);
    iq.disp_valid   = 1'b1;
    iq.disp_tag     = tag;
    iq.disp_opcode  = opc;
    iq.disp_rs_rdy  = rs_rdy;
    iq.disp_rs_data = rs_data;
    iq.disp_rs_tag  = rs_tag;
    iq.disp_rt_rdy  = rt_rdy;
    iq.disp_rt_data = rt_data;
    iq.disp_rt_tag  = rt_tag;
  endtask

  task automatic set_cdb(input logic [4:0] tag, input logic [31:0] data);
    iq.cdb_valid = 1'b1;
    iq.cdb_tag   = tag;
    iq.cdb_data  = data;
  endtask

  // Drive for one clock edge, then return all inputs to idle.
  task automatic step();
    tick();
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    nreset = 1'b0;

    // 1: reset state
    tick();
    tick();
    nreset = 1'b1;
    check_val("rst_int_ready", {31'd0, iq.int_ready}, 32'd0);
    check_val("rst_disp_ready", {31'd0, iq.disp_ready}, 32'd1);
    check_val("rst_int_tag", {27'd0, iq.int_tag}, 32'd0);
    check_val("rst_int_rs", iq.int_rs_data, 32'd0);

    // 2: ready op dispatched, presented next cycle, then issued
    set_disp(5'd3, OPC_SUB, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0);
    step();
    check_val("t2_int_ready", {31'd0, iq.int_ready}, 32'd1);
    check_val("t2_int_tag", {27'd0, iq.int_tag}, 32'd3);
    check_val("t2_int_rs", iq.int_rs_data, 32'd5);
    check_val("t2_int_rt", iq.int_rt_data, 32'd7);
    check_val("t2_int_opc", {28'd0, iq.int_opcode}, 32'd1);
    iq.int_issue = 1'b1;
    step();
    check_val("t2_after_issue", {31'd0, iq.int_ready}, 32'd0);
    check_val("t2_after_tag", {27'd0, iq.int_tag}, 32'd0);

    // 3: rs pending on tag 9, woken by CDB a cycle later
    set_disp(5'd4, OPC_ADD, 1'b0, 32'd0, 5'd9, 1'b1, 32'h11, 5'd0);
    step();
    check_val("t3_pending", {31'd0, iq.int_ready}, 32'd0);
    set_cdb(5'd9, 32'h1234);
    step();
    check_val("t3_woken_ready", {31'd0, iq.int_ready}, 32'd1);
    check_val("t3_woken_rs", iq.int_rs_data, 32'h1234);
    check_val("t3_woken_rt", iq.int_rt_data, 32'h11);
    check_val("t3_woken_tag", {27'd0, iq.int_tag}, 32'd4);
    iq.int_issue = 1'b1;
    step();

    // 4: CDB in the dispatch cycle is bypassed into the new entry
    set_disp(5'd5, OPC_AND, 1'b1, 32'h22, 5'd0, 1'b0, 32'd0, 5'd9);
    set_cdb(5'd9, 32'hBEEF);
    step();
    check_val("t4_bypass_ready", {31'd0, iq.int_ready}, 32'd1);
    check_val("t4_bypass_rt", iq.int_rt_data, 32'hBEEF);
    check_val("t4_bypass_tag", {27'd0, iq.int_tag}, 32'd5);
    iq.int_issue = 1'b1;
    step();

    // 5: full queue, only slots 1 and 3 ready
    set_disp(5'd10, OPC_ADD, 1'b0, 32'd0, 5'd20, 1'b1, 32'hB0, 5'd0);
    step();
    set_disp(5'd11, OPC_ADD, 1'b1, 32'hA1, 5'd0, 1'b1, 32'hB1, 5'd0);
    step();
    set_disp(5'd12, OPC_ADD, 1'b1, 32'hA2, 5'd0, 1'b0, 32'd0, 5'd21);
    step();
    set_disp(5'd13, OPC_ADD, 1'b1, 32'hA3, 5'd0, 1'b1, 32'hB3, 5'd0);
    step();
    check_val("t5_full_tag", {27'd0, iq.int_tag}, 32'd11);
    check_val("t5_full_disp_ready", {31'd0, iq.disp_ready}, 32'd0);
    set_disp(5'd14, OPC_ADD, 1'b1, 32'hEE, 5'd0, 1'b1, 32'hEE, 5'd0);
    iq.int_issue = 1'b1;
    step();
    check_val("t5_next_tag", {27'd0, iq.int_tag}, 32'd13);
    check_val("t5_next_rs", iq.int_rs_data, 32'hA3);
    check_val("t5_disp_ready", {31'd0, iq.disp_ready}, 32'd1);
    iq.int_issue = 1'b1;
    step();
    check_val("t5_none_ready", {31'd0, iq.int_ready}, 32'd0);
    set_cdb(5'd21, 32'h77);
    step();
    check_val("t5_wake12_tag", {27'd0, iq.int_tag}, 32'd12);
    check_val("t5_wake12_rt", iq.int_rt_data, 32'h77);
    set_cdb(5'd20, 32'h66);
    step();
    check_val("t5_oldest_tag", {27'd0, iq.int_tag}, 32'd10);
    check_val("t5_oldest_rs", iq.int_rs_data, 32'h66);
    iq.int_issue = 1'b1;
    step();
    check_val("t5_after10_tag", {27'd0, iq.int_tag}, 32'd12);
    iq.int_issue = 1'b1;
    step();
    check_val("t5_dropped_gone", {31'd0, iq.int_ready}, 32'd0);

    // Dispatch + issue + wakeup in one cycle, with a shift
    set_disp(5'd1, OPC_OR, 1'b1, 32'h1, 5'd0, 1'b1, 32'h2, 5'd0);
    step();
    set_disp(5'd2, OPC_OR, 1'b0, 32'd0, 5'd25, 1'b1, 32'h3, 5'd0);
    step();
    check_val("cmb_first_tag", {27'd0, iq.int_tag}, 32'd1);
    set_disp(5'd3, OPC_OR, 1'b1, 32'h30, 5'd0, 1'b1, 32'h31, 5'd0);
    set_cdb(5'd25, 32'h55);
    iq.int_issue = 1'b1;
    step();
    check_val("cmb_shift_tag", {27'd0, iq.int_tag}, 32'd2);
    check_val("cmb_shift_rs", iq.int_rs_data, 32'h55);
    check_val("cmb_shift_rt", iq.int_rt_data, 32'h3);
    iq.int_issue = 1'b1;
    step();
    check_val("cmb_ins_tag", {27'd0, iq.int_tag}, 32'd3);
    check_val("cmb_ins_rs", iq.int_rs_data, 32'h30);

    // 6: three entries held, flush with dispatch, issue and CDB
    set_disp(5'd6, OPC_XOR, 1'b0, 32'd0, 5'd30, 1'b1, 32'h6, 5'd0);
    step();
    set_disp(5'd7, OPC_XOR, 1'b1, 32'h7, 5'd0, 1'b1, 32'h7, 5'd0);
    step();
    check_val("t6_pre_disp_ready", {31'd0, iq.disp_ready}, 32'd1);
    iq.flush_valid = 1'b1;
    set_disp(5'd15, OPC_XOR, 1'b1, 32'hF, 5'd0, 1'b1, 32'hF, 5'd0);
    set_cdb(5'd30, 32'h99);
    iq.int_issue = 1'b1;
    step();
    check_val("t6_flush_ready", {31'd0, iq.int_ready}, 32'd0);
    check_val("t6_flush_disp_ready", {31'd0, iq.disp_ready}, 32'd1);
    check_val("t6_flush_tag", {27'd0, iq.int_tag}, 32'd0);
    set_disp(5'd8, OPC_SLT, 1'b1, 32'h88, 5'd0, 1'b1, 32'h89, 5'd0);
    step();
    check_val("t6_post_tag", {27'd0, iq.int_tag}, 32'd8);
    check_val("t6_post_rs", iq.int_rs_data, 32'h88);

    // Reset mid-operation empties the queue
    nreset = 1'b0;
    step();
    nreset = 1'b1;
    check_val("mid_rst_ready", {31'd0, iq.int_ready}, 32'd0);
    check_val("mid_rst_disp_ready", {31'd0, iq.disp_ready}, 32'd1);
    step();
    check_val("mid_rst_hold", {31'd0, iq.int_ready}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
